// File: rtl/spi_master_pkg.sv
// spi_master_pkg: frame state encoding and SPI mode decode helpers shared by
// the spi_master block and its clock generator.
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_TRANSFER = 3'd2,
        ST_HOLD     = 3'd3,
        ST_DONE     = 3'd4
    } spi_state_e;

    // Clock polarity: idle level of sclk.
    function automatic logic mode_cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    // Clock phase: 0 samples on the leading edge, 1 samples on the trailing edge.
    function automatic logic mode_cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: counts clk cycles per sclk half-period, toggles sclk while a
// transfer is running and flags the leading/trailing sclk edges.
module spi_clk_gen #(
    parameter int   CLK_DIV = 4,
    parameter logic CPOL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic toggle_en,
    output logic sclk,
    output logic tick,
    output logic lead,
    output logic trail
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] clk_counter_r;
    logic          sclk_r;
    logic          wrap_s;

    assign wrap_s = count_en && (clk_counter_r == CNT_LAST);
    assign tick   = wrap_s;
    // The edge type is known from the level sclk is about to leave.
    assign lead   = wrap_s && toggle_en && (sclk_r == CPOL);
    assign trail  = wrap_s && toggle_en && (sclk_r != CPOL);
    assign sclk   = sclk_r;

    // Half-period counter; sclk toggles on every wrap during a transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_counter_r <= {CW{1'b0}};
            sclk_r        <= CPOL;
        end else if (!count_en) begin
            clk_counter_r <= {CW{1'b0}};
            sclk_r        <= CPOL;
        end else begin
            clk_counter_r <= wrap_s ? {CW{1'b0}} : (clk_counter_r + CW'(1'b1));
            if (wrap_s && toggle_en) begin
                sclk_r <= ~sclk_r;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: one DATA_WIDTH-bit full-duplex SPI frame per start edge, MSB first.
// Frame-complete interrupt is generated only when SPI_MASTER_IRQ_EN is defined.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int MODE       = 0,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SLAVES = 1,
    parameter int CLK_DIV    = 4,
    parameter int SS_INDEX   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_tx,
    input  logic                  start_rx,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] ss_n,
    output logic                  irq
);

    localparam logic CPOL = mode_cpol(2'(MODE));
    localparam logic CPHA = mode_cpha(2'(MODE));
    localparam int   BW   = $clog2(DATA_WIDTH + 1);

    localparam logic [BW-1:0]         LAST_IDX  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0]         FULL_CNT  = BW'(DATA_WIDTH);
    localparam logic [NUM_SLAVES-1:0] SS_IDLE   = {NUM_SLAVES{1'b1}};
    localparam logic [NUM_SLAVES-1:0] SS_ACTIVE = SS_IDLE & ~(NUM_SLAVES'(1'b1) << SS_INDEX);

    spi_state_e state_r;
    spi_state_e state_next_s;

    logic                  tx_prev_r;
    logic                  rx_prev_r;
    logic                  tx_rise_s;
    logic                  rx_rise_s;
    logic                  start_s;
    logic [DATA_WIDTH-1:0] tx_sh_r;
    logic [DATA_WIDTH-1:0] rx_sh_r;
    logic [BW-1:0]         bit_cnt_r;
    logic                  mosi_r;
    logic                  busy_r;
    logic [NUM_SLAVES-1:0] ss_n_r;
    logic [DATA_WIDTH-1:0] rx_data_r;
    logic                  sclk_s;
    logic                  tick_s;
    logic                  lead_s;
    logic                  trail_s;
    logic                  sample_s;
    logic                  shift_s;
    logic                  last_s;
    logic                  count_en_s;
    logic                  toggle_en_s;
    logic                  in_frame_next_s;

    assign tx_rise_s = start_tx & ~tx_prev_r;
    assign rx_rise_s = start_rx & ~rx_prev_r;
    assign start_s   = (state_r == ST_IDLE) && (tx_rise_s || rx_rise_s);

    assign count_en_s  = (state_r == ST_SETUP) || (state_r == ST_TRANSFER) || (state_r == ST_HOLD);
    assign toggle_en_s = (state_r == ST_TRANSFER);

    // With CPHA=1 the MSB is already on mosi, so the first leading edge must not shift.
    assign sample_s = CPHA ? trail_s : lead_s;
    assign shift_s  = CPHA ? (lead_s && (bit_cnt_r != {BW{1'b0}})) : trail_s;
    assign last_s   = trail_s && (bit_cnt_r == (CPHA ? LAST_IDX : FULL_CNT));

    assign in_frame_next_s = (state_next_s == ST_SETUP) ||
                             (state_next_s == ST_TRANSFER) ||
                             (state_next_s == ST_HOLD);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_en  (count_en_s),
        .toggle_en (toggle_en_s),
        .sclk      (sclk_s),
        .tick      (tick_s),
        .lead      (lead_s),
        .trail     (trail_s)
    );

    // Frame state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_next_s = ST_SETUP;
                else         state_next_s = ST_IDLE;
            end
            ST_SETUP: begin
                if (tick_s) state_next_s = ST_TRANSFER;
                else        state_next_s = ST_SETUP;
            end
            ST_TRANSFER: begin
                if (last_s) state_next_s = ST_HOLD;
                else        state_next_s = ST_TRANSFER;
            end
            ST_HOLD: begin
                if (tick_s) state_next_s = ST_DONE;
                else        state_next_s = ST_HOLD;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Start edge history, shift registers, bit counter and serial output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_prev_r <= 1'b0;
            rx_prev_r <= 1'b0;
            tx_sh_r   <= {DATA_WIDTH{1'b0}};
            rx_sh_r   <= {DATA_WIDTH{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            mosi_r    <= 1'b0;
        end else begin
            tx_prev_r <= start_tx;
            rx_prev_r <= start_rx;
            if (start_s) begin
                tx_sh_r   <= tx_rise_s ? tx_data : {DATA_WIDTH{1'b0}};
                mosi_r    <= tx_rise_s & tx_data[DATA_WIDTH-1];
                rx_sh_r   <= {DATA_WIDTH{1'b0}};
                bit_cnt_r <= {BW{1'b0}};
            end else if (state_r == ST_TRANSFER) begin
                if (sample_s) begin
                    rx_sh_r   <= {rx_sh_r[DATA_WIDTH-2:0], miso};
                    bit_cnt_r <= bit_cnt_r + BW'(1'b1);
                end
                if (shift_s) begin
                    tx_sh_r <= tx_sh_r << 1'b1;
                    mosi_r  <= tx_sh_r[DATA_WIDTH-2];
                end
            end else if (state_r == ST_DONE) begin
                mosi_r <= 1'b0;
            end
        end
    end

    // Status, slave select and received word, all registered from the upcoming state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            ss_n_r    <= SS_IDLE;
            rx_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            ss_n_r <= in_frame_next_s ? SS_ACTIVE : SS_IDLE;
            if ((state_r == ST_HOLD) && (state_next_s == ST_DONE)) begin
                rx_data_r <= rx_sh_r;
            end
        end
    end

`ifdef SPI_MASTER_IRQ_EN
    logic irq_r;

    // One-cycle pulse coinciding with the DONE state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (state_next_s == ST_DONE);
        end
    end

    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

    assign rx_data = rx_data_r;
    assign busy    = busy_r;
    assign sclk    = sclk_s;
    assign mosi    = mosi_r;
    assign ss_n    = ss_n_r;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: table-driven and randomised frames against a behavioural SPI
// slave, plus loopback instances in modes 1-3 and multi-cycle corner sequences.
module tb_spi_master;

    localparam int DW  = 16;
    localparam int CD  = 4;
    localparam int LAT = (2 * DW + 2) * CD + 1;
`ifdef SPI_MASTER_IRQ_EN
    localparam int IRQ_ON = 1;
`else
    localparam int IRQ_ON = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start_tx;
    logic          start_rx;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] rx_data0;
    logic          busy0;
    logic          sclk0;
    logic          mosi0;
    logic          miso0;
    logic [0:0]    ss_n0;
    logic          irq0;

    logic [DW-1:0] lp_rx   [1:3];
    logic          lp_busy [1:3];
    logic          lp_sclk [1:3];
    logic          lp_mosi [1:3];
    logic [2:0]    lp_ss_n [1:3];
    logic          lp_irq  [1:3];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_master #(.MODE(0), .DATA_WIDTH(DW), .NUM_SLAVES(1), .CLK_DIV(CD), .SS_INDEX(0)) dut (
        .clk(clk), .rst_n(rst_n), .start_tx(start_tx), .start_rx(start_rx), .tx_data(tx_data),
        .rx_data(rx_data0), .busy(busy0), .sclk(sclk0), .mosi(mosi0), .miso(miso0),
        .ss_n(ss_n0), .irq(irq0)
    );

    // Modes 1-3 with mosi looped back to miso and a non-zero select index.
    for (genvar m = 1; m < 4; m++) begin : g_lp
        spi_master #(.MODE(m), .DATA_WIDTH(DW), .NUM_SLAVES(3), .CLK_DIV(CD), .SS_INDEX(1)) dut_lp (
            .clk(clk), .rst_n(rst_n), .start_tx(start_tx), .start_rx(start_rx), .tx_data(tx_data),
            .rx_data(lp_rx[m]), .busy(lp_busy[m]), .sclk(lp_sclk[m]), .mosi(lp_mosi[m]),
            .miso(lp_mosi[m]), .ss_n(lp_ss_n[m]), .irq(lp_irq[m])
        );
    end

    // Behavioural mode-0 slave: presents slv_word MSB first, advancing on each falling sclk.
    int            fall_total = 0;
    int            fall_base  = 0;
    int            rise_total = 0;
    int            ss_bad     = 0;
    int            slv_idx;
    logic [DW-1:0] slv_word   = '0;
    logic [DW-1:0] mosi_cap   = '0;

    function automatic logic slave_bit(input logic [DW-1:0] w, input int idx);
        logic [DW-1:0] t;
        if (idx < 0 || idx >= DW) return 1'b0;
        t = w << idx;
        return t[DW-1];
    endfunction

    assign slv_idx = fall_total - fall_base;
    assign miso0   = slave_bit(slv_word, slv_idx);

    always @(negedge sclk0) fall_total = fall_total + 1;

    always @(posedge sclk0) begin
        rise_total = rise_total + 1;
        if (ss_n0[0]) ss_bad = ss_bad + 1;
        else          mosi_cap = {mosi_cap[DW-2:0], mosi0};
    end

    // Frame and interrupt counters sampled mid-cycle
    int   irq_total    = 0;
    int   irq_lp_total = 0;
    int   irq_long     = 0;
    int   frames_total = 0;
    logic irq_prev     = 1'b0;
    logic busy_prev    = 1'b0;
    always @(negedge clk) begin
        if (irq0) irq_total = irq_total + 1;
        if (irq0 && irq_prev) irq_long = irq_long + 1;
        for (int m = 1; m < 4; m++) if (lp_irq[m]) irq_lp_total = irq_lp_total + 1;
        if (busy0 && !busy_prev) frames_total = frames_total + 1;
        irq_prev  = irq0;
        busy_prev = busy0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy0), 32'd0);
        check({tag, "_ss"},   32'(ss_n0), 32'd1);
        check({tag, "_sclk"}, 32'(sclk0), 32'd0);
        check({tag, "_mosi"}, 32'(mosi0), 32'd0);
        for (int m = 1; m < 4; m++) begin
            check($sformatf("%s_lp%0d_sclk", tag, m), 32'(lp_sclk[m]), (m >= 2) ? 32'd1 : 32'd0);
            check($sformatf("%s_lp%0d_ss", tag, m), 32'(lp_ss_n[m]), 32'h7);
        end
    endtask

    task automatic run_frame(input string tag, input logic do_tx, input logic do_rx,
                             input logic [DW-1:0] word, input logic [DW-1:0] mword,
                             input logic [DW-1:0] exp_rx, input logic [DW-1:0] exp_mosi);
        int k;
        int rise0;
        int irq_b;
        int irq_lp_b;
        @(negedge clk);
        check({tag, "_pre_busy"}, 32'(busy0), 32'd0);
        slv_word  = mword;
        fall_base = fall_total;
        rise0     = rise_total;
        irq_b     = irq_total;
        irq_lp_b  = irq_lp_total;
        tx_data   = word;
        start_tx  = do_tx;
        start_rx  = do_rx;
        @(negedge clk);
        check({tag, "_busy_rise"}, 32'(busy0), 32'd1);
        k = 0;
        while (busy0 && k < 1000) begin
            @(negedge clk);
            k++;
            if (k == 3) begin
                start_tx = 1'b0;
                start_rx = 1'b0;
            end
            if (k == 10) begin
                check({tag, "_ss_act"}, 32'(ss_n0), 32'd0);
                check({tag, "_lp_ss_act"}, 32'(lp_ss_n[2]), 32'h5);
            end
        end
        start_tx = 1'b0;
        start_rx = 1'b0;
        check({tag, "_latency"}, 32'(k), 32'(LAT));
        @(negedge clk);
        check({tag, "_rx_data"}, 32'(rx_data0), 32'(exp_rx));
        check({tag, "_mosi_bits"}, 32'(mosi_cap), 32'(exp_mosi));
        check({tag, "_sclk_rises"}, 32'(rise_total - rise0), 32'(DW));
        check({tag, "_irq"}, 32'(irq_total - irq_b), 32'(IRQ_ON));
        check({tag, "_lp_irq"}, 32'(irq_lp_total - irq_lp_b), 32'(3 * IRQ_ON));
        for (int m = 1; m < 4; m++)
            check($sformatf("%s_lp%0d_rx", tag, m), 32'(lp_rx[m]), 32'(exp_mosi));
        check_idle({tag, "_end"});
    endtask

    typedef struct {
        string         name;
        logic          do_tx;
        logic          do_rx;
        logic [DW-1:0] tx;
        logic [DW-1:0] mword;
        logic [DW-1:0] exp_rx;
        logic [DW-1:0] exp_mosi;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int            k;
        int            f0;
        int            i0;
        int            r0;
        logic          rtx;
        logic          rrx;
        logic [DW-1:0] rw;
        logic [DW-1:0] rm;

        vecs[0] = '{"aa55",     1'b1, 1'b0, 16'hAA55, 16'h0000, 16'h0000, 16'hAA55};
        vecs[1] = '{"rx_ones",  1'b0, 1'b1, 16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[2] = '{"both",     1'b1, 1'b1, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
        vecs[3] = '{"msb_lsb",  1'b1, 1'b0, 16'h8001, 16'h7FFE, 16'h7FFE, 16'h8001};
        vecs[4] = '{"all_ones", 1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0001, 16'hFFFF};
        vecs[5] = '{"rx_pat",   1'b0, 1'b1, 16'hFFFF, 16'hC3A5, 16'hC3A5, 16'h0000};

        rst_n    = 1'b0;
        start_tx = 1'b0;
        start_rx = 1'b0;
        tx_data  = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_rx_data", 32'(rx_data0), 32'd0);
        check("reset_irq", 32'(irq0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].name, vecs[i].do_tx, vecs[i].do_rx, vecs[i].tx,
                      vecs[i].mword, vecs[i].exp_rx, vecs[i].exp_mosi);

        // Random frames: the slave returns its word, mosi carries tx_data or zeros.
        for (int i = 0; i < 8; i++) begin
            rtx = 1'($urandom_range(0, 1));
            rrx = rtx ? 1'($urandom_range(0, 1)) : 1'b1;
            rw  = DW'($urandom);
            rm  = DW'($urandom);
            run_frame($sformatf("rand%0d", i), rtx, rrx, rw, rm, rm, rtx ? rw : '0);
        end

        // A second start_tx edge mid-frame, held high afterwards, must be ignored.
        f0 = frames_total;
        i0 = irq_total;
        @(negedge clk);
        slv_word  = 16'h0F0F;
        fall_base = fall_total;
        tx_data   = 16'hCCCC;
        start_tx  = 1'b1;
        repeat (40) @(negedge clk);
        start_tx = 1'b0;
        repeat (20) @(negedge clk);
        check("retrig_busy_mid", 32'(busy0), 32'd1);
        tx_data  = 16'h3333;
        start_tx = 1'b1;
        k = 0;
        while (busy0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        repeat (200) @(negedge clk);
        check("retrig_frames", 32'(frames_total - f0), 32'd1);
        check("retrig_rx_data", 32'(rx_data0), 32'h0F0F);
        check("retrig_mosi_bits", 32'(mosi_cap), 32'hCCCC);
        check("retrig_irq", 32'(irq_total - i0), 32'(IRQ_ON));
        check("retrig_busy_end", 32'(busy0), 32'd0);
        start_tx = 1'b0;

        // Back-to-back frames separated by 50 clock periods (500 ns at 10 ns).
        f0 = frames_total;
        i0 = irq_total;
        for (int i = 0; i < 3; i++) begin
            rw = DW'(i * 16'h1111);
            run_frame($sformatf("b2b%0d", i), 1'b1, 1'b0, rw, ~rw, ~rw, rw);
            repeat (48) @(negedge clk);
        end
        check("b2b_frames", 32'(frames_total - f0), 32'd3);
        check("b2b_irqs", 32'(irq_total - i0), 32'(3 * IRQ_ON));

        // Reset after five sclk periods of a 0x1111 frame.
        @(negedge clk);
        r0        = rise_total;
        fall_base = fall_total;
        tx_data   = 16'h1111;
        start_tx  = 1'b1;
        k = 0;
        while ((rise_total - r0) < 5 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("midrst_bits", 32'(rise_total - r0), 32'd5);
        check("midrst_busy_before", 32'(busy0), 32'd1);
        rst_n    = 1'b0;
        start_tx = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        check("midrst_rx_data", 32'(rx_data0), 32'd0);
        for (int m = 1; m < 4; m++)
            check($sformatf("midrst_lp%0d_rx", m), 32'(lp_rx[m]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("post_rst", 1'b1, 1'b0, 16'hA5C3, 16'h5A3C, 16'h5A3C, 16'hA5C3);

        check("irq_width", 32'(irq_long), 32'd0);
        check("ss_at_edges", 32'(ss_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
